// File: rtl/ber_meas_ctrl_pkg.sv
// Shared types for the BER measurement sequencer: FSM states, status codes, default counter width.
package ber_pkg;

    localparam int NB_CNT_DEF = 64;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RESET = 3'd1,
        S_SYNC  = 3'd2,
        S_MEAS  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        ST_NONE = 2'b00,
        ST_OK   = 2'b01,
        ST_STOP = 2'b10,
        ST_TMO  = 2'b11
    } status_t;

endpackage

// File: rtl/ber_meas_ctrl.sv
// Sequencer for one BER counter: reset, sync wait, windowed count, snapshot and done pulse.
// Optional sync timeout is compiled in with `define BER_CTRL_TIMEOUT_EN.
module ber_meas_ctrl
    import ber_pkg::*;
#(
    parameter int NB_CNT     = NB_CNT_DEF,
    parameter int RST_CYCLES = 4,
    parameter int NB_TMO     = 20
) (
    input  logic              clock,
    input  logic              i_reset_n,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic [NB_CNT-1:0] i_window,
    input  logic              i_valid,
    input  logic [NB_CNT-1:0] i_bits,
    input  logic [NB_CNT-1:0] i_errors,
    output logic              o_ber_reset,
    output logic              o_ber_valid,
    output logic              o_busy,
    output logic              o_done,
    output logic [1:0]        o_status,
    output logic [NB_CNT-1:0] o_errors,
    output logic [NB_CNT-1:0] o_bits
);

    localparam int NB_RST = $clog2(RST_CYCLES + 1);

    state_t              state_q, state_d;
    logic [NB_RST-1:0]   rst_cnt_q, rst_cnt_d;
    logic [NB_CNT-1:0]   window_q, window_d;
    status_t             pend_q, pend_d;
    status_t             status_q, status_d;
    logic [NB_CNT-1:0]   errors_q, errors_d;
    logic [NB_CNT-1:0]   bits_q, bits_d;
    logic                done_q, done_d;
`ifdef BER_CTRL_TIMEOUT_EN
    logic [NB_TMO-1:0]   tmo_q, tmo_d;
`endif

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        window_d  = window_q;
        pend_d    = pend_q;
        status_d  = status_q;
        errors_d  = errors_q;
        bits_d    = bits_q;
        done_d    = 1'b0;
`ifdef BER_CTRL_TIMEOUT_EN
        tmo_d     = tmo_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d   = S_RESET;
                    window_d  = i_window;
                    rst_cnt_d = NB_RST'(RST_CYCLES - 1);
                end
            end
            S_RESET: begin
`ifdef BER_CTRL_TIMEOUT_EN
                tmo_d = '0;
`endif
                if (rst_cnt_q == '0) begin
                    state_d = S_SYNC;
                end else begin
                    rst_cnt_d = rst_cnt_q - 1'b1;
                end
            end
            S_SYNC: begin
                // Sync is declared once the counter has accepted its first bit.
                if (i_stop) begin
                    pend_d  = ST_STOP;
                    state_d = S_DONE;
                end else if (i_bits != '0) begin
                    state_d = S_MEAS;
`ifdef BER_CTRL_TIMEOUT_EN
                end else if (&tmo_q) begin
                    pend_d  = ST_TMO;
                    state_d = S_DONE;
                end else if (i_valid) begin
                    tmo_d = tmo_q + 1'b1;
`endif
                end
            end
            S_MEAS: begin
                if ((window_q != '0) && (i_bits >= window_q)) begin
                    pend_d  = ST_OK;
                    state_d = S_DONE;
                end else if (i_stop) begin
                    pend_d  = ST_STOP;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // Snapshot and done pulse become visible together on the following cycle.
                status_d = pend_q;
                errors_d = i_errors;
                bits_d   = i_bits;
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= S_IDLE;
            rst_cnt_q <= '0;
            window_q  <= '0;
            pend_q    <= ST_NONE;
            status_q  <= ST_NONE;
            errors_q  <= '0;
            bits_q    <= '0;
            done_q    <= 1'b0;
`ifdef BER_CTRL_TIMEOUT_EN
            tmo_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            rst_cnt_q <= rst_cnt_d;
            window_q  <= window_d;
            pend_q    <= pend_d;
            status_q  <= status_d;
            errors_q  <= errors_d;
            bits_q    <= bits_d;
            done_q    <= done_d;
`ifdef BER_CTRL_TIMEOUT_EN
            tmo_q     <= tmo_d;
`endif
        end
    end

    assign o_ber_reset = (state_q == S_IDLE) || (state_q == S_RESET);
    assign o_ber_valid = i_valid && ((state_q == S_SYNC) || (state_q == S_MEAS));
    assign o_busy      = (state_q != S_IDLE);
    assign o_done      = done_q;
    assign o_status    = status_q;
    assign o_errors    = errors_q;
    assign o_bits      = bits_q;

endmodule

// File: tb/tb_ber_meas_ctrl.sv
// Bench for ber_meas_ctrl with a behavioural BER counter; scoreboard checks each done snapshot.
module tb_ber_meas_ctrl;

    localparam int NB = 64;

    logic          clock = 1'b0;
    logic          rst_n;
    logic          start, stop, valid;
    logic [NB-1:0] window;
    logic [NB-1:0] cnt_bits, cnt_err;
    logic          ber_reset, ber_valid, busy, done;
    logic [1:0]    status;
    logic [NB-1:0] snap_err, snap_bits;

    logic link_ok;
    logic inject;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    typedef struct {
        logic [1:0]    st;
        logic [NB-1:0] err_lo, err_hi, bits_lo, bits_hi;
    } exp_t;
    exp_t exp_q[$];

    always #5 clock = ~clock;

    ber_meas_ctrl #(.NB_CNT(NB), .RST_CYCLES(4), .NB_TMO(8)) dut (
        .clock      (clock),
        .i_reset_n  (rst_n),
        .i_start    (start),
        .i_stop     (stop),
        .i_window   (window),
        .i_valid    (valid),
        .i_bits     (cnt_bits),
        .i_errors   (cnt_err),
        .o_ber_reset(ber_reset),
        .o_ber_valid(ber_valid),
        .o_busy     (busy),
        .o_done     (done),
        .o_status   (status),
        .o_errors   (snap_err),
        .o_bits     (snap_bits)
    );

    // Counter model: one bit per valid strobe once the link carries data; optional 1 error per 100 bits.
    always @(posedge clock) begin
        if (ber_reset) begin
            cnt_bits <= '0;
            cnt_err  <= '0;
        end else if (ber_valid && link_ok) begin
            cnt_bits <= cnt_bits + 1;
            if (inject && (cnt_bits % 100 == 99)) cnt_err <= cnt_err + 1;
        end
    end

    task automatic chk(input string name, input logic [NB-1:0] act,
                       input logic [NB-1:0] lo, input logic [NB-1:0] hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s: actual=%0d required=[%0d..%0d]", name, act, lo, hi);
        end else begin
            $display("ok   %s: actual=%0d", name, act);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clock) begin
        if (rst_n && done) begin
            exp_t e;
            done_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: actual=done required=no done (status=%0d bits=%0d)",
                         status, snap_bits);
            end else begin
                e = exp_q.pop_front();
                chk("done_status", {62'd0, status}, {62'd0, e.st}, {62'd0, e.st});
                chk("done_errors", snap_err, e.err_lo, e.err_hi);
                chk("done_bits", snap_bits, e.bits_lo, e.bits_hi);
            end
        end
    end

    task automatic push(input logic [1:0] st, input longint el, input longint eh,
                        input longint bl, input longint bh);
        exp_t e;
        e.st = st; e.err_lo = el; e.err_hi = eh; e.bits_lo = bl; e.bits_hi = bh;
        exp_q.push_back(e);
    endtask

    task automatic pulse_start(input logic [NB-1:0] w);
        @(posedge clock); #1 start = 1'b1; window = w;
        @(posedge clock); #1 start = 1'b0;
    endtask

    task automatic pulse_stop();
        @(posedge clock); #1 stop = 1'b1;
        @(posedge clock); #1 stop = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(posedge clock);
            n++;
        end
        @(negedge clock);
        if (done_cnt < target) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: actual=%0d dones required=%0d", done_cnt, target);
        end
    endtask

    task automatic wait_sync(input int budget);
        int n = 0;
        while (cnt_bits == 0 && n < budget) begin
            @(posedge clock); #1;
            n++;
        end
        if (cnt_bits == 0) begin
            checks++;
            failures++;
            $display("FAIL sync_timeout: actual=bits 0 required=nonzero");
        end
    endtask

    initial begin
        int d0;
        rst_n = 1'b0; start = 0; stop = 0; valid = 1'b1; window = '0;
        link_ok = 1'b1; inject = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_ber_reset", {63'd0, ber_reset}, 1, 1);
        chk("rst_ber_valid", {63'd0, ber_valid}, 0, 0);
        chk("rst_busy", {63'd0, busy}, 0, 0);
        chk("rst_done", {63'd0, done}, 0, 0);
        chk("rst_status", {62'd0, status}, 0, 0);
        chk("rst_bits", snap_bits, 0, 0);
        #1 rst_n = 1'b1;

        // 1: error-free, window 1000
        push(2'b01, 0, 0, 1000, 1001);
        pulse_start(64'd1000);
        wait_done(1, 2000);

        // 2: 1 error per 100 bits, window 10000
        inject = 1'b1;
        push(2'b01, 99, 101, 10000, 10001);
        pulse_start(64'd10000);
        wait_done(2, 12000);
        inject = 1'b0;

        // 3: open window, stop after 5000 cycles of counting
        push(2'b10, 0, 0, 4999, 5003);
        pulse_start(64'd0);
        wait_sync(100);
        repeat (4999) @(posedge clock);
        pulse_stop();
        wait_done(3, 100);
        @(negedge clock);
        chk("t3_ber_valid_after_done", {63'd0, ber_valid}, 0, 0);
        chk("t3_busy_after_done", {63'd0, busy}, 0, 0);

        // 4: stop while waiting for sync; a second start while busy is ignored
        valid = 1'b0;
        push(2'b10, 0, 0, 0, 0);
        pulse_start(64'd500);
        repeat (10) @(posedge clock);
        pulse_start(64'd7);
        pulse_stop();
        wait_done(4, 100);
        repeat (20) @(posedge clock);
        @(negedge clock);
        chk("t4_single_done", done_cnt, 4, 4);

        // 5: link dead, strobes after an idle gap
        link_ok = 1'b0;
`ifdef BER_CTRL_TIMEOUT_EN
        push(2'b11, 0, 0, 0, 0);
`endif
        pulse_start(64'd100);
        repeat (20) @(posedge clock);
        for (int i = 0; i < 600; i++) begin
            @(posedge clock); #1 valid = ~valid;
        end
`ifdef BER_CTRL_TIMEOUT_EN
        wait_done(5, 100);
        @(negedge clock);
        chk("t5_busy_after_tmo", {63'd0, busy}, 0, 0);
`else
        @(negedge clock);
        chk("t5_still_busy", {63'd0, busy}, 1, 1);
        push(2'b10, 0, 0, 0, 0);
        pulse_stop();
        wait_done(5, 100);
`endif
        link_ok = 1'b1;

        // 6: async reset during measurement
        valid = 1'b1;
        pulse_start(64'd0);
        wait_sync(100);
        repeat (50) @(posedge clock);
        #2 rst_n = 1'b0;
        @(negedge clock);
        chk("t6_ber_reset", {63'd0, ber_reset}, 1, 1);
        chk("t6_busy", {63'd0, busy}, 0, 0);
        chk("t6_status", {62'd0, status}, 0, 0);
        chk("t6_bits", snap_bits, 0, 0);
        chk("t6_done", {63'd0, done}, 0, 0);
        d0 = done_cnt;
        repeat (3) @(posedge clock);
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clock);
        @(negedge clock);
        chk("t6_no_done", done_cnt, d0, d0);
        chk("t6_queue_empty", exp_q.size(), 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
